// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, BCD digit type,
// digit limits and the preset validity check.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t MAX_SEC_TENS = 4'd5;
    localparam bcd_digit_t MAX_DIGIT    = 4'd9;

    function automatic logic preset_valid(input logic [7:0] set_min, input logic [7:0] set_sec);
        return (set_min[7:4] <= MAX_DIGIT) && (set_min[3:0] <= MAX_DIGIT) &&
               (set_sec[7:4] <= MAX_SEC_TENS) && (set_sec[3:0] <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Command/preset inputs and display/status outputs of the countdown timer.
interface countdown_timer_ctrl_if;

    logic       Start;
    logic       Pause;
    logic       Clear;
    logic       Load;
    logic [7:0] SetMin;
    logic [7:0] SetSec;
    logic [7:0] MinBcd;
    logic [7:0] SecBcd;
    logic       Running;
    logic       Expired;
    logic       Done;
    logic       LoadErr;
    logic       Beep;

    modport master (
        output Start, Pause, Clear, Load, SetMin, SetSec,
        input  MinBcd, SecBcd, Running, Expired, Done, LoadErr, Beep
    );

    modport slave (
        input  Start, Pause, Clear, Load, SetMin, SetSec,
        output MinBcd, SecBcd, Running, Expired, Done, LoadErr, Beep
    );

endinterface

// File: rtl/countdown_timer_ctrl_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, Tick on the last count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic En,
    input  logic Clr,
    output logic Tick,
    output logic FirstHalf
);

    localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr) begin
            cnt_d = '0;
        end else if (En) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick      = En && !Clr && (cnt_q == LAST);
    assign FirstHalf = (cnt_q < HALF);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// MM:SS BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// Optional post-expiry alarm on Beep is enabled with macro COUNTDOWN_BEEP_EN.
module countdown_timer_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned BEEP_SECS = 5
) (
    input logic                   Clk,
    input logic                   Rst_n,
    countdown_timer_ctrl_if.slave bus
);

    import timer_pkg::*;

    state_t     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       running_q, expired_q, done_q, load_err_q;
    logic       done_d, load_err_d;
    logic [7:0] min_dec, sec_dec;
    logic       tick, pre_en, pre_clr, load_ok, count_nz, at_one;

    assign load_ok  = preset_valid(bus.SetMin, bus.SetSec);
    assign count_nz = (min_q != '0) || (sec_q != '0);
    assign at_one   = (min_q == '0) && (sec_q == 8'h01);

    // Pause freezes the prescaler in the very cycle it is sampled, so the phase
    // left behind is exactly the one seen when Pause was applied.
    assign pre_clr = bus.Clear || (state_q == ST_IDLE) || ((state_q == ST_EXPIRED) && bus.Load);
`ifdef COUNTDOWN_BEEP_EN
    assign pre_en  = ((state_q == ST_RUN) && !bus.Pause) || (state_q == ST_EXPIRED);
`else
    assign pre_en  = (state_q == ST_RUN) && !bus.Pause;
`endif

`ifdef COUNTDOWN_BEEP_EN
    logic first_half;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .En       (pre_en),
        .Clr      (pre_clr),
        .Tick     (tick),
        .FirstHalf(first_half)
    );
`else
    logic unused_first_half;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .En       (pre_en),
        .Clr      (pre_clr),
        .Tick     (tick),
        .FirstHalf(unused_first_half)
    );
`endif

    always_comb begin
        sec_dec = sec_q;
        min_dec = min_q;
        if (sec_q[3:0] != 4'd0) begin
            sec_dec[3:0] = sec_q[3:0] - 4'd1;
        end else begin
            sec_dec[3:0] = MAX_DIGIT;
            if (sec_q[7:4] != 4'd0) begin
                sec_dec[7:4] = sec_q[7:4] - 4'd1;
            end else begin
                sec_dec[7:4] = MAX_SEC_TENS;
                if (min_q[3:0] != 4'd0) begin
                    min_dec[3:0] = min_q[3:0] - 4'd1;
                end else begin
                    min_dec[3:0] = MAX_DIGIT;
                    min_dec[7:4] = min_q[7:4] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.Clear) begin
            state_d = ST_IDLE;
            min_d   = '0;
            sec_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_EXPIRED: begin
                    if (bus.Load) begin
                        if (load_ok) begin
                            state_d = ST_IDLE;
                            min_d   = bus.SetMin;
                            sec_d   = bus.SetSec;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else if ((state_q == ST_IDLE) && bus.Start && count_nz) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.Pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (at_one) begin
                            state_d = ST_EXPIRED;
                            min_d   = '0;
                            sec_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            min_d = min_dec;
                            sec_d = sec_dec;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.Start && !bus.Pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            min_q      <= '0;
            sec_q      <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            running_q  <= (state_d == ST_RUN);
            expired_q  <= (state_d == ST_EXPIRED);
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef COUNTDOWN_BEEP_EN
    localparam int unsigned BW = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;

    logic [BW-1:0] secs_left_q, secs_left_d;
    logic          beep_q, beep_d;

    // Seconds of alarm left; armed on expiry, counted down by ticks in EXPIRED.
    always_comb begin
        secs_left_d = secs_left_q;
        if (state_d != ST_EXPIRED) begin
            secs_left_d = '0;
        end else if (state_q == ST_RUN) begin
            secs_left_d = BW'(BEEP_SECS);
        end else if (bus.Load) begin
            secs_left_d = '0;
        end else if (tick && (secs_left_q != '0)) begin
            secs_left_d = secs_left_q - 1'b1;
        end
    end

    assign beep_d = (state_q == ST_EXPIRED) && (state_d == ST_EXPIRED) && !bus.Load &&
                    (secs_left_q != '0) && first_half;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            secs_left_q <= '0;
            beep_q      <= 1'b0;
        end else begin
            secs_left_q <= secs_left_d;
            beep_q      <= beep_d;
        end
    end

    assign bus.Beep = beep_q;
`else
    assign bus.Beep = 1'b0;
`endif

    assign bus.MinBcd  = min_q;
    assign bus.SecBcd  = sec_q;
    assign bus.Running = running_q;
    assign bus.Expired = expired_q;
    assign bus.Done    = done_q;
    assign bus.LoadErr = load_err_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: seconds-level reference model checked every cycle
// plus directed scenarios with literal expectations (TICK_DIV=10, BEEP_SECS=2).
module tb_countdown_timer_ctrl;

    localparam int TD = 10;
    localparam int BS = 2;
`ifdef COUNTDOWN_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    countdown_timer_ctrl_if bus();

    countdown_timer_ctrl #(.TICK_DIV(TD), .BEEP_SECS(BS)) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model tracks the remaining time as a plain number of seconds.
    typedef struct {
        int mode;
        int secs;
        int phase;
        int bsecs;
        bit done;
        bit err;
        bit beep;
    } mdl_t;

    mdl_t m;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t cur, input logic st, input logic ps, input logic cl,
                                  input logic ld, input logic [7:0] sm, input logic [7:0] ss);
        mdl_t n;
        bit   adv;
        bit   tk;
        bit   valid;
        n      = cur;
        n.done = 1'b0;
        n.err  = 1'b0;
        n.beep = 1'b0;
        adv    = (cur.mode == M_RUN && !ps) || (BEEP_ON && cur.mode == M_EXP);
        tk     = adv && (cur.phase == TD - 1);
        if (adv) n.phase = tk ? 0 : cur.phase + 1;
        if (cl) begin
            n.mode  = M_IDLE;
            n.secs  = 0;
            n.phase = 0;
            n.bsecs = 0;
            return n;
        end
        valid = (int'(sm[7:4]) <= 9) && (int'(sm[3:0]) <= 9) && (int'(ss[7:4]) <= 5) && (int'(ss[3:0]) <= 9);
        if (cur.mode == M_IDLE || cur.mode == M_EXP) begin
            if (ld) begin
                n.phase = 0;
                n.bsecs = 0;
                if (valid) begin
                    n.mode = M_IDLE;
                    n.secs = bcd2int(sm) * 60 + bcd2int(ss);
                end else begin
                    n.err = 1'b1;
                end
            end else if (cur.mode == M_IDLE) begin
                if (st && cur.secs > 0) n.mode = M_RUN;
            end else begin
                n.beep = BEEP_ON && (cur.bsecs > 0) && (cur.phase < TD / 2);
                if (tk && cur.bsecs > 0) n.bsecs = cur.bsecs - 1;
            end
        end else if (cur.mode == M_RUN) begin
            if (ps) begin
                n.mode = M_PAUSE;
            end else if (tk) begin
                n.secs = cur.secs - 1;
                if (n.secs == 0) begin
                    n.mode  = M_EXP;
                    n.done  = 1'b1;
                    n.bsecs = BS;
                end
            end
        end else begin
            if (st && !ps) n.mode = M_RUN;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{M_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        else        m <= step(m, bus.Start, bus.Pause, bus.Clear, bus.Load, bus.SetMin, bus.SetSec);
    end

    function automatic logic [20:0] exp_vec(input mdl_t x);
        return {int2bcd(x.secs / 60), int2bcd(x.secs % 60), (x.mode == M_RUN), (x.mode == M_EXP),
                x.done, x.err, x.beep};
    endfunction

    function automatic logic [20:0] act_vec();
        return {bus.MinBcd, bus.SecBcd, bus.Running, bus.Expired, bus.Done, bus.LoadErr, bus.Beep};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) check("model_cycle", 32'(act_vec()), 32'(exp_vec(m)));

    task automatic load(input logic [7:0] sm, input logic [7:0] ss);
        bus.SetMin = sm;
        bus.SetSec = ss;
        bus.Load   = 1'b1;
        @(negedge clk);
        bus.Load   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.Clear = 1'b1;
        @(negedge clk);
        bus.Clear = 1'b0;
    endtask

    initial begin
        int done_at;
        int beep_high;
        bus.Start  = 1'b0;
        bus.Pause  = 1'b0;
        bus.Clear  = 1'b0;
        bus.Load   = 1'b0;
        bus.SetMin = 8'h00;
        bus.SetSec = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(act_vec()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 01:05 runs to expiry in 65 seconds of 10 cycles each
        load(8'h01, 8'h05);
        check("load_0105", {bus.MinBcd, bus.SecBcd}, 16'h0105);
        pulse_start();
        check("running_after_start", 32'(bus.Running), 32'd1);
        done_at = -1;
        for (int i = 1; i <= 700 && done_at < 0; i++) begin
            @(negedge clk);
            if (bus.Done) done_at = i;
        end
        check("done_latency", done_at, 650);
        check("expired_display", {bus.MinBcd, bus.SecBcd, bus.Expired}, {16'h0000, 1'b1});
        beep_high = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            beep_high += int'(bus.Beep);
        end
        check("beep_high_cycles", beep_high, BEEP_ON ? 10 : 0);
        bus.Start = 1'b1;
        bus.Pause = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Pause = 1'b0;
        check("expired_holds", {bus.Expired, bus.Running}, 2'b10);
        pulse_clear();

        // 10:00 borrows across all digits
        load(8'h10, 8'h00);
        pulse_start();
        repeat (9) @(negedge clk);
        check("before_first_tick", {bus.MinBcd, bus.SecBcd}, 16'h1000);
        @(negedge clk);
        check("first_tick_0959", {bus.MinBcd, bus.SecBcd}, 16'h0959);
        repeat (2) @(negedge clk);
        load(8'h05, 8'h05);
        check("load_ignored_in_run", {bus.MinBcd, bus.SecBcd, bus.Running}, {16'h0959, 1'b1});
        repeat (7) @(negedge clk);
        check("second_tick_0958", {bus.MinBcd, bus.SecBcd}, 16'h0958);
        pulse_clear();

        // pause with the prescaler at 4, resume 20 cycles later
        load(8'h00, 8'h30);
        pulse_start();
        repeat (4) @(negedge clk);
        bus.Pause = 1'b1;
        repeat (20) @(negedge clk);
        check("paused_hold", {bus.MinBcd, bus.SecBcd, bus.Running}, {16'h0030, 1'b0});
        bus.Pause = 1'b0;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (5) @(negedge clk);
        check("resume_pre_tick", {bus.MinBcd, bus.SecBcd, bus.Running}, {16'h0030, 1'b1});
        @(negedge clk);
        check("resume_tick_6", {bus.MinBcd, bus.SecBcd}, 16'h0029);
        pulse_clear();

        // Clear beats Load; invalid presets are rejected
        load(8'h05, 8'h00);
        bus.SetMin = 8'h07;
        bus.SetSec = 8'h07;
        bus.Clear  = 1'b1;
        bus.Load   = 1'b1;
        @(negedge clk);
        bus.Clear  = 1'b0;
        bus.Load   = 1'b0;
        check("clear_over_load", {bus.MinBcd, bus.SecBcd, bus.Running, bus.Expired}, {16'h0000, 2'b00});
        load(8'h02, 8'h22);
        check("load_0222", {bus.MinBcd, bus.SecBcd}, 16'h0222);
        load(8'h01, 8'h6A);
        check("bad_sec_err", {bus.MinBcd, bus.SecBcd, bus.LoadErr}, {16'h0222, 1'b1});
        @(negedge clk);
        check("err_one_cycle", 32'(bus.LoadErr), 32'd0);
        load(8'hA0, 8'h00);
        check("bad_min_err", {bus.MinBcd, bus.SecBcd, bus.LoadErr}, {16'h0222, 1'b1});
        pulse_clear();
        pulse_start();
        repeat (5) @(negedge clk);
        check("start_at_zero", {bus.MinBcd, bus.SecBcd, bus.Running}, {16'h0000, 1'b0});

        // asynchronous reset in the middle of a run
        load(8'h03, 8'h20);
        pulse_start();
        repeat (30) @(negedge clk);
        check("run_0317", {bus.MinBcd, bus.SecBcd, bus.Running}, {16'h0317, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(act_vec()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("post_reset_idle", {bus.MinBcd, bus.SecBcd, bus.Running}, {16'h0000, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000: Clk cycles per one-second tick.
REQ-002 SHALL have parameter BEEP_SECS, default 5: alarm duration in seconds after expiry.
REQ-003 SHALL have port Clk, input, 1 bit: system clock, 100 MHz, rising edge.
REQ-004 SHALL have port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Start, input, 1 bit: level-sampled start/resume command.
REQ-006 SHALL have port Pause, input, 1 bit: pause command.
REQ-007 SHALL have port Clear, input, 1 bit: abort and zero command.
REQ-008 SHALL have port Load, input, 1 bit: load preset command.
REQ-009 SHALL have port SetMin, input, 8 bits: BCD minutes preset, {tens,ones}, 00-99.
REQ-010 SHALL have port SetSec, input, 8 bits: BCD seconds preset, {tens,ones}, 00-59.
REQ-011 SHALL have port MinBcd, output, 8 bits: current BCD minutes.
REQ-012 SHALL have port SecBcd, output, 8 bits: current BCD seconds.
REQ-013 SHALL have port Running, output, 1 bit: high in RUN.
REQ-014 SHALL have port Expired, output, 1 bit: high in EXPIRED.
REQ-015 SHALL have port Done, output, 1 bit: one-cycle pulse on expiry.
REQ-016 SHALL have port LoadErr, output, 1 bit: one-cycle pulse when an invalid preset is rejected.
REQ-017 SHALL have port Beep, output, 1 bit: audible alarm drive.

Function
REQ-018 SHALL implement the states IDLE, RUN, PAUSE and EXPIRED; all outputs SHALL be registered.
REQ-019 SHALL apply command priority per cycle as Clear > Load > Pause > Start.
REQ-020 SHALL, on Clear in any state, enter IDLE, set count to 00:00 and zero the prescaler on the next edge.
REQ-021 SHALL accept Load only in IDLE or EXPIRED: a valid preset is copied to MinBcd/SecBcd and the state becomes IDLE.
REQ-022 SHALL treat a preset as invalid if any digit > 9 or the seconds tens digit > 5; an invalid preset SHALL leave the count unchanged and pulse LoadErr.
REQ-023 SHALL ignore Load in RUN or PAUSE.
REQ-024 SHALL, on Start in IDLE with a nonzero count, enter RUN with the prescaler zeroed, so the first tick occurs TICK_DIV cycles later; Start with count 00:00 SHALL be ignored.
REQ-025 SHALL, on Pause in RUN, enter PAUSE with the prescaler frozen (not zeroed); Start in PAUSE SHALL resume RUN from the frozen phase.
REQ-026 SHALL, when Start and Pause are both asserted in RUN, pause.
REQ-027 SHALL have a prescaler that counts 0..TICK_DIV-1 only in RUN and produces an internal tick on the cycle the count equals TICK_DIV-1, after which it wraps to 0.
REQ-028 SHALL, on each tick, decrement the BCD count on the same edge:
 - ones digit 0 -> 9 with borrow from the tens digit;
 - seconds 00 -> 59 with borrow from the minutes.
REQ-029 SHALL, on a tick at 00:01, set the count to 00:00, enter EXPIRED, pulse Done for one cycle and hold Expired high.
REQ-030 SHALL leave the state unchanged on Start or Pause in EXPIRED; only Clear or Load exits EXPIRED.

Reset
REQ-031 SHALL, while Rst_n is low, immediately force state IDLE, prescaler 0, MinBcd/SecBcd 0x00, and Running, Expired, Done, LoadErr and Beep to 0, including mid-RUN.

Configuration
REQ-032 SHALL, with macro COUNTDOWN_BEEP_EN defined:
 - keep the prescaler running in EXPIRED;
 - drive Beep high during the first half of each second (prescaler < TICK_DIV/2) for BEEP_SECS seconds after expiry, then hold it 0;
 - stop Beep on Clear or Load.
REQ-033 SHALL, without COUNTDOWN_BEEP_EN, tie Beep to 0 and hold the prescaler in EXPIRED.

Structure
REQ-034 SHALL place the state enum, the 4-bit BCD digit type and the constants MAX_SEC_TENS=5 and MAX_DIGIT=9 in the shared package timer_pkg.
REQ-035 SHALL implement the prescaler as sub-module tick_prescaler with ports Clk, Rst_n, En, Clr, Tick and FirstHalf.

Verification (benches SHALL use TICK_DIV=10, BEEP_SECS=2)
REQ-036 SHALL cover: Load 01:05, then Start -> Running=1; Done pulses exactly 650 cycles after Start; display 00:00; Expired=1.
REQ-037 SHALL cover: Load 10:00, then Start -> after the first tick the display reads 09:59; after the next tick it reads 09:58.
REQ-038 SHALL cover: Pause asserted when the prescaler is at 4, held for 20 cycles, then Start -> the next tick occurs 6 cycles after resume; the count does not change while paused.
REQ-039 SHALL cover: Clear and Load in the same cycle -> IDLE at 00:00; a Load with SetSec=0x6A -> LoadErr pulse and count unchanged; Start at 00:00 -> stays IDLE.
REQ-040 SHALL cover: Rst_n low at 03:17 mid-RUN -> all outputs 0 asynchronously; after release the state is IDLE and ticks no longer decrement.
REQ-041 SHALL cover: COUNTDOWN_BEEP_EN defined -> Beep is high 5 cycles of every 10 for 20 cycles after Done, then 0. Macro undefined -> Beep stays 0.
